// File: rtl/timer_sched_pkg.sv
// Shared time-base definitions: scheduler state encoding and default sizes
// reused by every consumer of the prescaled tick.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int PRESCALE_DEFAULT = 500;
  localparam int CNT_W_DEFAULT    = 16;

  // Modulo-n increment used for round-robin pointer updates.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Requester-side bundle of the shared timer scheduler. The requester
// logic is the master; the scheduler is the slave.
interface timer_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_delay;
  logic                  abort;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  tick;

  modport master (
    output req, req_delay, abort,
    input  gnt, done, busy, tick
  );

  modport slave (
    input  req, req_delay, abort,
    output gnt, done, busy, tick
  );
endinterface

// File: rtl/timer_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int cand;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/timer_scheduler.sv
// Shared prescaled countdown timer, granted round-robin to NREQ requesters;
// returns a one-cycle done strobe to the requester that owned the job.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input logic               clk_in,
  input logic               reset,
  timer_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int PS_W  = $clog2(PRESCALE);

  sched_state_t     state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] winner_reg;
  logic [PS_W-1:0]  presc_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic [NREQ-1:0]  done_reg;
  logic             busy_reg;
  logic             tick_reg;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [CNT_W-1:0] pick_delay;
  logic [NREQ-1:0]  win_onehot;
  logic [CNT_W-1:0] delay_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign delay_arr[gi]  = bus.req_delay[gi*CNT_W +: CNT_W];
      assign win_onehot[gi] = (winner_reg == IDX_W'(gi));
    end
  endgenerate

  assign pick_delay = delay_arr[pick_idx];

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // tick_reg is precomputed one cycle ahead so it is high exactly while
  // presc_reg == PRESCALE-1 in RUN, without a combinational output path.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      winner_reg    <= '0;
      presc_reg     <= '0;
      remaining_reg <= '0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      busy_reg      <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          presc_reg <= '0;
          done_reg  <= '0;
          tick_reg  <= 1'b0;
          if (pick_valid) begin
            winner_reg    <= pick_idx;
            remaining_reg <= (pick_delay == '0) ? CNT_W'(1) : pick_delay;
            gnt_reg       <= pick_onehot;
            busy_reg      <= 1'b1;
            state_reg     <= RUN;
          end else begin
            gnt_reg  <= '0;
            busy_reg <= 1'b0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            // Abort beats a coincident final tick: no done strobe.
            state_reg <= IDLE;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
            tick_reg  <= 1'b0;
            presc_reg <= '0;
            ptr_reg   <= IDX_W'(wrap_inc(int'(winner_reg), NREQ));
          end else if (presc_reg == PS_W'(PRESCALE - 1)) begin
            presc_reg     <= '0;
            tick_reg      <= 1'b0;
            remaining_reg <= remaining_reg - CNT_W'(1);
            if (remaining_reg == CNT_W'(1)) begin
              state_reg <= DONE;
              gnt_reg   <= '0;
              done_reg  <= win_onehot;
            end
          end else begin
            presc_reg <= presc_reg + PS_W'(1);
            tick_reg  <= (presc_reg == PS_W'(PRESCALE - 2));
          end
        end
        DONE: begin
          done_reg  <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
          ptr_reg   <= IDX_W'(wrap_inc(int'(winner_reg), NREQ));
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
          done_reg  <= '0;
          busy_reg  <= 1'b0;
          tick_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_reg;
  assign bus.done = done_reg;
  assign bus.busy = busy_reg;
  assign bus.tick = tick_reg;

endmodule
